reg_bank_arbiter: RTL and testbench

//   Shares one write port of a DEPTH x WIDTH register bank between NREQ requesters.

---
 rtl/reg_bank_arbiter.sv | 111 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one registered write port of a flop bank.
// Async read port bypasses the pending write so a grant is visible next cycle.
module reg_bank_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  wr_fire,
    output logic [IDW-1:0]        wr_id
);

    logic [WIDTH-1:0] bank [DEPTH];
    logic [IDW-1:0]   ptr;
    logic             stg_valid;
    logic [AW-1:0]    stg_addr;
    logic [WIDTH-1:0] stg_data;
    logic [IDW-1:0]   stg_id;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gid;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             accept;
    logic [IDW-1:0]   ptr_nxt;

    // Scan from ptr with wraparound; first valid requester wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = idx;
            end
        end
        if (!rst || clr) begin
            grant = '0;
            gid   = '0;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign ptr_nxt   = IDW'((int'(gid) + 1) % NREQ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
            stg_id    <= '0;
        end else if (clr) begin
            ptr       <= '0;
            stg_valid <= 1'b0;
            stg_addr  <= '0;
            stg_data  <= '0;
            stg_id    <= '0;
        end else begin
            if (accept) begin
                ptr <= ptr_nxt;
            end
            stg_valid <= accept;
            stg_addr  <= req_addr[int'(gid)*AW +: AW];
            stg_data  <= req_data[int'(gid)*WIDTH +: WIDTH];
            stg_id    <= gid;
        end
    end

    // Clear wins over the pending commit so a dropped write never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                bank[e] <= RESET_VAL;
            end
        end else if (clr) begin
            for (int e = 0; e < DEPTH; e++) begin
                bank[e] <= RESET_VAL;
            end
        end else if (stg_valid) begin
            bank[stg_addr] <= stg_data;
        end
    end

    always_comb begin
        rd_data = bank[rd_addr];
        if (stg_valid && (stg_addr == rd_addr)) begin
            rd_data = stg_data;
        end
    end

    assign wr_fire = stg_valid;
    assign wr_id   = stg_id;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single write, fairness,
// skip, same-address collision, clear and async reset mid-burst.
module tb_reg_bank_arbiter;

    localparam int NREQ = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clr;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic                  wr_fire;
    logic [1:0]            wr_id;

    int checks = 0;
    int errors = 0;

    reg_bank_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_fire(wr_fire), .wr_id(wr_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [WIDTH-1:0] d);
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        rd_addr = '0;

        // 1: reset
        step();
        req_valid = 4'b0001;
        #1;
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        req_valid = '0;
        step();
        rst = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            chk($sformatf("rst_rd%0d", a), rd_data, 32'h0);
        end
        chk("rst_fire", 32'(wr_fire), 32'h0);
        chk("rst_id", 32'(wr_id), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);

        // 2: single request, bypass then commit
        step();
        set_req(0, 3'd3, 32'hA5);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        rd_addr = 3'd3;
        #1;
        chk("single_fire", 32'(wr_fire), 32'h1);
        chk("single_id", 32'(wr_id), 32'h0);
        chk("single_bypass", rd_data, 32'hA5);
        step();
        chk("single_fire_off", 32'(wr_fire), 32'h0);
        chk("single_bank", rd_data, 32'hA5);

        // clear pulse: bank wiped, ptr back to 0
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        chk("clr_bank3", rd_data, 32'h0);

        // 3: fairness
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(i), 32'h10 + 32'(i));
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("fair%0d", c), 32'(req_ready), 32'h1 << (c % 4));
            step();
            chk($sformatf("fair_id%0d", c), 32'(wr_id), 32'(c % 4));
        end
        req_valid = '0;
        step();
        rd_addr = 3'd2;
        #1;
        chk("fair_bank2", rd_data, 32'h12);

        // 4: skip from ptr=1 with valid=1001
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1001;
        #1;
        chk("skip_grant3", 32'(req_ready), 32'h8);
        step();
        chk("skip_grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;

        // 5: same-address collision, ptr=1
        set_req(1, 3'd5, 32'h11);
        set_req(2, 3'd5, 32'h22);
        rd_addr = 3'd5;
        req_valid = 4'b0010;
        #1;
        chk("coll_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0100;
        #1;
        chk("coll_ready2", 32'(req_ready), 32'h4);
        chk("coll_rd_first", rd_data, 32'h11);
        step();
        req_valid = '0;
        #1;
        chk("coll_rd_second", rd_data, 32'h22);
        chk("coll_id", 32'(wr_id), 32'h2);
        step();
        chk("coll_bank", rd_data, 32'h22);
        chk("coll_fire_off", 32'(wr_fire), 32'h0);

        // 6: clear drops pending write, ptr=3 -> grant 0
        set_req(0, 3'd2, 32'h7);
        req_valid = 4'b0001;
        rd_addr = 3'd2;
        #1;
        chk("clr_acc_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1111;
        clr = 1'b1;
        #1;
        chk("clr_ready", 32'(req_ready), 32'h0);
        chk("clr_rd_unaff", rd_data, 32'h7);
        chk("clr_fire", 32'(wr_fire), 32'h1);
        step();
        clr = 1'b0;
        req_valid = '0;
        #1;
        chk("clr_dropped", rd_data, 32'h0);
        chk("clr_fire_off", 32'(wr_fire), 32'h0);
        req_valid = 4'b1111;
        #1;
        chk("clr_ptr0", 32'(req_ready), 32'h1);

        // async reset mid-burst
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(i + 4), 32'h40 + 32'(i));
        end
        step();
        step();
        rd_addr = 3'd4;
        #1;
        chk("burst_bank4", rd_data, 32'h40);
        rst = 1'b0;
        #1;
        chk("arst_fire", 32'(wr_fire), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_bank4", rd_data, 32'h0);
        rd_addr = 3'd5;
        #1;
        chk("arst_bank5", rd_data, 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("arst_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
